// File: rtl/timestamp_event_tagger.sv
// timestamp_event_tagger: captures the live timestamp on each detector event into a FWFT record FIFO
// and flags dropped events and counter wrap-around.
module timestamp_event_tagger #(
    parameter int CHANNEL_WIDTH = 4,
    parameter int FIFO_DEPTH    = 16,
    parameter int DROP_WIDTH    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [63:0]                  timestamp,
    input  logic                         event_valid,
    input  logic [CHANNEL_WIDTH-1:0]     event_channel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_timestamp,
    output logic [CHANNEL_WIDTH-1:0]     out_channel,
    output logic                         out_lost,
    output logic                         out_wrap,
    output logic [DROP_WIDTH-1:0]        dropped_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = 66 + CHANNEL_WIDTH;

    logic [RW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         count_q, count_d;
    logic [DROP_WIDTH-1:0] dropped_q, dropped_d;
    logic                  lost_pending_q, lost_pending_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [63:0]           prev_ts_q, prev_ts_d;
    logic                  run_q;
    logic                  capture, pop, full, push, drop, run_rise, wrap;
    logic [RW-1:0]         rec;

    always_comb begin
        capture        = run && event_valid;
        pop            = (count_q != '0) && out_ready;
        full           = count_q == LW'(FIFO_DEPTH);
        push           = capture && (!full || pop);
        drop           = capture && full && !pop;
        // A fresh run must never compare against a timestamp from the previous run.
        run_rise       = run && !run_q;
        wrap           = prev_valid_q && !run_rise && (timestamp < prev_ts_q);
        rec            = {timestamp, event_channel, lost_pending_q, wrap};
        wr_ptr_d       = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d       = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d        = count_q + LW'(push) - LW'(pop);
        dropped_d      = (drop && dropped_q != '1) ? dropped_q + DROP_WIDTH'(1) : dropped_q;
        lost_pending_d = push ? 1'b0 : (drop ? 1'b1 : lost_pending_q);
        prev_valid_d   = push ? 1'b1 : (run_rise ? 1'b0 : prev_valid_q);
        prev_ts_d      = push ? timestamp : prev_ts_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            dropped_q      <= '0;
            lost_pending_q <= 1'b0;
            prev_valid_q   <= 1'b0;
            prev_ts_q      <= '0;
            run_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            dropped_q      <= dropped_d;
            lost_pending_q <= lost_pending_d;
            prev_valid_q   <= prev_valid_d;
            prev_ts_q      <= prev_ts_d;
            run_q          <= run;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= rec;
    end

    always_comb begin
        out_valid     = count_q != '0;
        {out_timestamp, out_channel, out_lost, out_wrap} = out_valid ? mem_q[rd_ptr_q] : '0;
        fifo_level    = count_q;
        dropped_count = dropped_q;
    end
endmodule

// File: tb/tb_timestamp_event_tagger.sv
// tb_timestamp_event_tagger: table-driven vectors plus directed overflow, wrap and mid-run reset sequences.
module tb_timestamp_event_tagger;
    logic        clk = 0, reset = 0, run = 0, event_valid = 0, out_ready = 0;
    logic [63:0] timestamp = 0;
    logic [3:0]  event_channel = 0;
    logic        out_valid, out_lost, out_wrap;
    logic [63:0] out_timestamp;
    logic [3:0]  out_channel;
    logic [31:0] dropped_count;
    logic [4:0]  fifo_level;
    int          tests = 0, fails = 0;

    timestamp_event_tagger dut (
        .clk(clk), .reset(reset), .run(run), .timestamp(timestamp),
        .event_valid(event_valid), .event_channel(event_channel),
        .out_valid(out_valid), .out_ready(out_ready), .out_timestamp(out_timestamp),
        .out_channel(out_channel), .out_lost(out_lost), .out_wrap(out_wrap),
        .dropped_count(dropped_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, run, ev;
        logic [3:0]  ch;
        logic [63:0] ts;
        logic        rdy, vld;
        logic [63:0] ets;
        logic [3:0]  ech;
        logic        elost, ewrap;
        logic [4:0]  lvl;
        logic [31:0] drop;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic rst, run_i, ev, input logic [3:0] ch, input logic [63:0] ts,
                                input logic rdy, vld, input logic [63:0] ets, input logic [3:0] ech,
                                input logic elost, ewrap, input logic [4:0] lvl, input logic [31:0] drop);
        vec_t v;
        v.rst = rst; v.run = run_i; v.ev = ev; v.ch = ch; v.ts = ts; v.rdy = rdy; v.vld = vld;
        v.ets = ets; v.ech = ech; v.elost = elost; v.ewrap = ewrap; v.lvl = lvl; v.drop = drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, ru, ev, input logic [3:0] ch, input logic [63:0] ts, input logic rdy);
        reset = r; run = ru; event_valid = ev; event_channel = ch; timestamp = ts; out_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 1, 3, 100, 0, 1, 100, 3, 0, 0, 1, 0);
        vecs[4]  = mk(0, 1, 0, 0, 101, 0, 1, 100, 3, 0, 0, 1, 0);
        vecs[5]  = mk(0, 1, 0, 0, 102, 1, 0, 0,   0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            vecs[6+i] = mk(0, 0, 1, 7, 64'(200 + i), 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 1, 5, 50,  0, 1, 50,  5, 0, 0, 1, 0);
        vecs[12] = mk(0, 1, 1, 6, 40,  0, 1, 50,  5, 0, 0, 2, 0);
        vecs[13] = mk(0, 1, 0, 0, 41,  1, 1, 40,  6, 0, 1, 1, 0);
        vecs[14] = mk(0, 1, 0, 0, 42,  1, 0, 0,   0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].ev, vecs[i].ch, vecs[i].ts, vecs[i].rdy);
            tick();
            chk($sformatf("v%0d valid", i), 64'(out_valid), 64'(vecs[i].vld));
            chk($sformatf("v%0d ts", i), out_timestamp, vecs[i].ets);
            chk($sformatf("v%0d ch", i), 64'(out_channel), 64'(vecs[i].ech));
            chk($sformatf("v%0d lost", i), 64'(out_lost), 64'(vecs[i].elost));
            chk($sformatf("v%0d wrap", i), 64'(out_wrap), 64'(vecs[i].ewrap));
            chk($sformatf("v%0d level", i), 64'(fifo_level), 64'(vecs[i].lvl));
            chk($sformatf("v%0d dropped", i), 64'(dropped_count), 64'(vecs[i].drop));
        end

        // Overflow: 18 events into a 16-deep FIFO, then a push coinciding with a pop while full
        drive(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 18; i++) begin
            logic [63:0] t;
            t = 64'(10 + i);
            drive(0, 1, 1, t[3:0], t, 0);
            tick();
        end
        chk("ovf level", 64'(fifo_level), 16);
        chk("ovf dropped", 64'(dropped_count), 2);
        chk("ovf head ts", out_timestamp, 10);
        chk("ovf head lost", 64'(out_lost), 0);
        drive(0, 1, 1, 4'd8, 40, 1);
        tick();
        chk("fullpop level", 64'(fifo_level), 16);
        chk("fullpop dropped", 64'(dropped_count), 2);
        chk("fullpop head ts", out_timestamp, 11);
        drive(0, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            logic [63:0] t;
            t = (k < 16) ? 64'(10 + k) : 64'd40;
            chk($sformatf("drain%0d valid", k), 64'(out_valid), 1);
            chk($sformatf("drain%0d ts", k), out_timestamp, t);
            chk($sformatf("drain%0d ch", k), 64'(out_channel), 64'(t[3:0]));
            chk($sformatf("drain%0d lost", k), 64'(out_lost), 64'(k == 16));
            chk($sformatf("drain%0d wrap", k), 64'(out_wrap), 0);
            tick();
        end
        chk("drained valid", 64'(out_valid), 0);
        chk("drained level", 64'(fifo_level), 0);

        // Wrap-around across 2^64 and run re-arm
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 1, 4'd1, 64'hffffffffffffffce, 0);
        tick();
        chk("wrap1 ts", out_timestamp, 64'hffffffffffffffce);
        chk("wrap1 wrap", 64'(out_wrap), 0);
        drive(0, 1, 1, 4'd2, 0, 0);
        tick();
        chk("wrap2 level", 64'(fifo_level), 2);
        drive(0, 1, 0, 0, 1, 1);
        tick();
        chk("wrap2 ts", out_timestamp, 0);
        chk("wrap2 ch", 64'(out_channel), 2);
        chk("wrap2 wrap", 64'(out_wrap), 1);
        tick();
        chk("wrap empty", 64'(fifo_level), 0);
        drive(0, 0, 0, 0, 2, 1);
        tick();
        drive(0, 1, 1, 4'd3, 5, 1);
        tick();
        chk("rerun valid", 64'(out_valid), 1);
        chk("rerun ts", out_timestamp, 5);
        chk("rerun wrap", 64'(out_wrap), 0);
        drive(0, 1, 0, 0, 6, 1);
        tick();
        chk("rerun level", 64'(fifo_level), 0);

        // Mid-operation reset discards records, drop count and pending loss flag
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 1, 4'd9, 64'(100 + i), 0);
            tick();
        end
        chk("pre-rst level", 64'(fifo_level), 16);
        chk("pre-rst dropped", 64'(dropped_count), 1);
        drive(1, 1, 0, 0, 0, 0);
        tick();
        chk("rst valid", 64'(out_valid), 0);
        chk("rst level", 64'(fifo_level), 0);
        chk("rst dropped", 64'(dropped_count), 0);
        chk("rst ts", out_timestamp, 0);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post-rst%0d valid", i), 64'(out_valid), 0);
        end
        drive(0, 1, 1, 4'd4, 7, 0);
        tick();
        chk("post-rst ts", out_timestamp, 7);
        chk("post-rst lost", 64'(out_lost), 0);
        chk("post-rst level", 64'(fifo_level), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/timestamp_event_tagger.md
Name: timestamp_event_tagger

Overview:
- Consumer end of the free-running 64-bit timestamp bus driven by timestamp_generator.
- On each detector event it captures the current timestamp with a channel ID and buffers the record in a FIFO.
- It presents records on a valid/ready stream to the readout/packetizer path.
- It flags dropped events and 64-bit counter wrap-around.

Parameters:
- CHANNEL_WIDTH, 4, width of event channel ID.
- FIFO_DEPTH, 16, record buffer depth; power of two, at least 2.
- DROP_WIDTH, 32, width of saturating dropped-event counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  acquisition enable, same signal as feeds timestamp_generator.
- timestamp  input  64  live count from timestamp_generator.
- event_valid  input  1  one-cycle event strobe, synchronous to clk.
- event_channel  input  CHANNEL_WIDTH  channel ID, qualified by event_valid.
- out_valid  output  1  record available.
- out_ready  input  1  downstream accepts record.
- out_timestamp  output  64  captured timestamp.
- out_channel  output  CHANNEL_WIDTH  captured channel.
- out_lost  output  1  one or more events were dropped immediately before this record.
- out_wrap  output  1  this timestamp is numerically below the previously captured one, i.e. the counter wrapped.
- dropped_count  output  DROP_WIDTH  saturating count of events dropped since reset.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  records held.

Behaviour:
- Reset: one clock, synchronous, active-high; the clock is named clk and the reset is named reset.
  - Held for one or more cycles, reset empties the FIFO and clears dropped_count, lost_pending and the prev_valid/prev_ts history.
  - All outputs are 0 after reset (out_valid=0, fifo_level=0, record fields 0).
  - Reset mid-operation discards buffered records without emitting them.
- Capture: on an edge where run=1 and event_valid=1, the record {timestamp, event_channel, lost_pending, wrap} is sampled in that same cycle.
  - timestamp is the value present on the sampling edge; no pipeline skew is added.
- Events with run=0 are ignored: no record is written and dropped_count does not change.
- Latency: with the FIFO empty, out_valid=1 and the fields are valid in the cycle after the capture edge (1 cycle).
  - Output is first-word-fall-through from FIFO storage.
- Handshake:
  - A record pops on an edge with out_valid=1 and out_ready=1.
  - Fields hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop, except on reset.
- Full FIFO:
  - An event arriving with fifo_level==FIFO_DEPTH and no simultaneous pop is dropped.
  - dropped_count increments, saturating at all-ones, and lost_pending is set.
  - An event that coincides with a pop while full is accepted; the level stays at FIFO_DEPTH.
- Empty FIFO: a push and a pop cannot coincide because out_valid=0, so the level goes 0→1.
- lost_pending:
  - Copied into out_lost of the next accepted record, then cleared on that same edge.
  - Persists across run deassertion until a record is accepted or reset occurs.
- Wrap detection:
  - wrap=1 iff prev_valid=1 and the captured timestamp < prev_ts (unsigned 64-bit compare).
  - prev_ts and prev_valid update only on accepted records.
  - On a rising edge of run (run=1, previous run=0), prev_valid is cleared, so the first record of each run has wrap=0.
- Run deassertion stops capture only; buffered records keep draining normally.
- fifo_level is registered and reflects the state after the current edge.

Test Plan:
- Reset + single event: reset 3 cycles, run=1, event ch=3 while timestamp=100.
  → next cycle out_valid=1, out_timestamp=100, out_channel=3, out_lost=0, out_wrap=0; pop with out_ready=1 → fifo_level=0.
- run gating: run=0, 5 events.
  → fifo_level stays 0, dropped_count=0, out_valid=0.
- Overflow/drop: out_ready=0, 18 events at consecutive timestamps 10..27 (FIFO_DEPTH=16).
  → fifo_level=16, dropped_count=2. Then out_ready=1 and one more event at ts=40: 16 records 10..25 drain in order with out_lost=0; the 17th record has ts=40 and out_lost=1.
- Full with simultaneous pop: FIFO full, out_ready=1 and an event on the same edge.
  → fifo_level stays 16, dropped_count unchanged, and the new record appears last in order.
- Wrap: events at timestamp=2^64-50 (ffffffffffffffce) and then at timestamp=0.
  → first record out_wrap=0, second out_wrap=1. Toggle run 1→0→1, event at ts=5 → out_wrap=0.
- Reset mid-operation: 5 records buffered, out_ready=0, assert reset 1 cycle.
  → out_valid=0, fifo_level=0, dropped_count=0 the next cycle; no stale record is emitted afterwards.
